mode_counter: RTL and testbench

//   Parametrised multi-mode counter: zero / up / down / up-down (ping-pong).

---
 rtl/mode_counter.sv | 122 ++++++++++++
 tb/tb_mode_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// mode_counter: prescaled multi-mode counter (zero / up / down / ping-pong).
// The prescaler is a clock enable on clk; no derived clocks.
// Optional feature: define MODE_COUNTER_LOAD_EN to add the load / load_val
// parallel-load ports. Without it the block has no load ports.
module mode_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       sel,
`ifdef MODE_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tick,
  output logic             wrap
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX      = '1;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_PING = 2'd3
  } mode_t;

  logic [DIV_W-1:0] pre;
  logic             step;
  mode_t            mode;
  logic             load_now;
  logic [WIDTH-1:0] load_data;

`ifdef MODE_COUNTER_LOAD_EN
  assign load_now  = load;
  assign load_data = load_val;
`else
  assign load_now  = 1'b0;
  assign load_data = '0;
`endif

  // Step strobe and decoded mode for the current cycle.
  always_comb begin
    step = en && (pre == PRE_LAST);
    mode = mode_t'(sel);
  end

  // Prescaler: free-running modulo-DIV counter while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
    end
  end

  // Count, direction and the tick/wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= 1'b0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= step;
      wrap <= 1'b0;
      if (load_now) begin
        count <= load_data;
      end else begin
        unique case (mode)
          MODE_ZERO: begin
            count <= '0;
            dir   <= 1'b0;
          end
          MODE_UP: begin
            if (step) begin
              count <= count + 1'b1;
              dir   <= 1'b0;
              wrap  <= (count == MAX);
            end
          end
          MODE_DOWN: begin
            if (step) begin
              count <= count - 1'b1;
              dir   <= 1'b1;
              wrap  <= (count == '0);
            end
          end
          MODE_PING: begin
            if (step) begin
              if (!dir) begin
                if (count == MAX) begin
                  count <= MAX - 1'b1;
                  dir   <= 1'b1;
                  wrap  <= 1'b1;
                end else begin
                  count <= count + 1'b1;
                end
              end else begin
                if (count == '0) begin
                  count <= {{(WIDTH-1){1'b0}}, 1'b1};
                  dir   <= 1'b0;
                  wrap  <= 1'b1;
                end else begin
                  count <= count - 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter: WIDTH=4/DIV=3 main instance plus a WIDTH=1/DIV=1
// instance sharing the same controls, both compared every cycle against an
// integer reference model (ping-pong modelled as a position on a triangle).
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] count;
  logic       dir, tick, wrap;
  logic [0:0] count1;
  logic       dir1, tick1, wrap1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
`ifdef MODE_COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .count(count), .dir(dir), .tick(tick), .wrap(wrap)
  );

  mode_counter #(.WIDTH(1), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
`ifdef MODE_COUNTER_LOAD_EN
    .load(load), .load_val(load_val[0:0]),
`endif
    .count(count1), .dir(dir1), .tick(tick1), .wrap(wrap1)
  );

  typedef struct {
    int pre;
    int cnt;
    bit dir;
    bit tick;
    bit wrap;
  } ms_t;

  ms_t m, m1;
  localparam ms_t MS_RESET = '{pre: 0, cnt: 0, dir: 1'b0, tick: 1'b0, wrap: 1'b0};

  function automatic ms_t mnext(ms_t s, int width, int div, bit e, bit [1:0] md,
                                bit ld, int lv);
    ms_t n;
    int  top, per, p, q;
    bit  st;
    n = s;
    top = (1 << width) - 1;
    st = e && (s.pre == div - 1);
    if (e) n.pre = (s.pre + 1) % div;
    n.tick = st;
    n.wrap = 1'b0;
    if (ld) begin
      n.cnt = lv % (top + 1);
    end else if (md == 2'd0) begin
      n.cnt = 0;
      n.dir = 1'b0;
    end else if (st) begin
      if (md == 2'd1) begin
        n.cnt  = (s.cnt + 1) % (top + 1);
        n.dir  = 1'b0;
        n.wrap = (s.cnt == top);
      end else if (md == 2'd2) begin
        n.cnt  = (s.cnt + top) % (top + 1);
        n.dir  = 1'b1;
        n.wrap = (s.cnt == 0);
      end else begin
        // Position on a triangle wave of period 2*top.
        per = 2 * top;
        p = s.dir ? (per - s.cnt) % per : s.cnt;
        q = (p + 1) % per;
        n.cnt  = (q <= top) ? q : per - q;
        n.dir  = (q > top) || (q == 0);
        n.wrap = (!s.dir && s.cnt == top) || (s.dir && s.cnt == 0);
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("count", int'(count), m.cnt);
    check("dir", int'(dir), int'(m.dir));
    check("tick", int'(tick), int'(m.tick));
    check("wrap", int'(wrap), int'(m.wrap));
    check("count1", int'(count1), m1.cnt);
    check("dir1", int'(dir1), int'(m1.dir));
    check("tick1", int'(tick1), int'(m1.tick));
    check("wrap1", int'(wrap1), int'(m1.wrap));
  endtask

  task automatic cyc();
    bit ld;
    @(posedge clk);
`ifdef MODE_COUNTER_LOAD_EN
    ld = load;
`else
    ld = 1'b0;
`endif
    if (!rst_n) begin
      m  = MS_RESET;
      m1 = MS_RESET;
    end else begin
      m  = mnext(m, 4, 3, en, sel, ld, int'(load_val));
      m1 = mnext(m1, 1, 1, en, sel, ld, int'(load_val));
    end
    #1;
    compare_all();
  endtask

  task automatic run(input int n, output int ticks, output int wraps, output int dchg);
    bit d0;
    ticks = 0; wraps = 0; dchg = 0;
    for (int i = 0; i < n; i++) begin
      d0 = dir;
      cyc();
      ticks += int'(tick);
      wraps += int'(wrap);
      if (dir != d0) dchg++;
    end
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    m = MS_RESET; m1 = MS_RESET;
    cyc();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int t, w, d, n;
    m = MS_RESET; m1 = MS_RESET;

    // Reset state.
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    #2 rst_n = 1'b1;

    // Count up to 7, then async reset between edges.
    sel = 2'd1; en = 1'b1;
    n = 0;
    while (m.cnt != 7 && n < 100) begin cyc(); n++; end
    check("reach_7", int'(count), 7);
    #2 rst_n = 1'b0;
    #1;
    m = MS_RESET; m1 = MS_RESET;
    check("async_count", int'(count), 0);
    check("async_tick", int'(tick), 0);
    check("async_wrap", int'(wrap), 0);
    check("async_dir", int'(dir), 0);
    #2 rst_n = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 10);
    check("first_tick_latency", n, 3);

    // Up count from 0 across the wrap, then hold with en=0.
    reset_pulse();
    run(48, t, w, d);
    check("up_ticks", t, 16);
    check("up_wraps", w, 1);
    check("up_end", int'(count), 0);
    en = 1'b0;
    run(10, t, w, d);
    check("hold_ticks", t + w, 0);
    check("hold_count", int'(count), 0);

    // Down count from 0.
    en = 1'b1; sel = 2'd2;
    run(3, t, w, d);
    check("down_first", int'(count), 15);
    check("down_first_wrap", int'(wrap), 1);
    check("down_dir", int'(dir), 1);
    run(45, t, w, d);
    check("down_wraps", w, 0);
    check("down_end", int'(count), 0);

    // Ping-pong from 0 with dir=0: 0..15..0..1.
    reset_pulse();
    sel = 2'd3;
    run(93, t, w, d);
    check("ping_wraps", w, 2);
    check("ping_dirchg", d, 2);
    check("ping_end", int'(count), 1);

    // Zero mode is immediate, not tick-gated.
    sel = 2'd1;
    n = 0;
    while (m.cnt != 9 && n < 200) begin cyc(); n++; end
    check("reach_9", int'(count), 9);
    sel = 2'd0;
    cyc();
    check("zero_count", int'(count), 0);
    check("zero_dir", int'(dir), 0);
    sel = 2'd1;
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 10);
    check("restart_up", int'(count), 1);

`ifdef MODE_COUNTER_LOAD_EN
    // Load overrides zero mode.
    sel = 2'd0; load = 1'b1; load_val = 4'd12;
    cyc();
    load = 1'b0;
    check("load_12", int'(count), 12);
    // Get dir=1, then ping-pong with a load of 15.
    sel = 2'd2;
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 10);
    sel = 2'd3; load = 1'b1; load_val = 4'd15;
    cyc();
    load = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!tick && n < 10);
    check("load_then_down", int'(count), 14);
`endif

    // Randomised mode/enable/load traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
`ifdef MODE_COUNTER_LOAD_EN
      load = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
`endif
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
